// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order PC tag
// queue, instruction buffer toward decode, and redirect flush/discard.
module fetch_unit #(
   parameter int                   REGI_SIZE  = 16,
   parameter int                   FIFO_DEPTH = 4,
   parameter logic [REGI_SIZE-1:0] RESET_PC   = '0,
   parameter logic [REGI_SIZE-1:0] PC_STEP    = REGI_SIZE'(1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 redirect_i,
   input  logic [REGI_SIZE-1:0] redirect_pc_i,
   output logic                 imem_req_o,
   output logic [REGI_SIZE-1:0] imem_addr_o,
   input  logic                 imem_rvalid_i,
   input  logic [REGI_SIZE-1:0] imem_rdata_i,
   output logic                 instr_valid_o,
   input  logic                 instr_ready_i,
   output logic [REGI_SIZE-1:0] instr_o,
   output logic [REGI_SIZE-1:0] pc_o,
   output logic [REGI_SIZE-1:0] next_pc_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

   logic [REGI_SIZE-1:0] fetch_pc;
   logic [CW-1:0]        outstanding;
   logic [CW-1:0]        discard_cnt;
   logic [CW-1:0]        buf_count;
   logic [AW-1:0]        buf_rd;
   logic [AW-1:0]        buf_wr;
   logic [AW-1:0]        tag_rd;
   logic [AW-1:0]        tag_wr;

   logic [REGI_SIZE-1:0] buf_pc  [FIFO_DEPTH];
   logic [REGI_SIZE-1:0] buf_ins [FIFO_DEPTH];
   logic [REGI_SIZE-1:0] tag_pc  [FIFO_DEPTH];

   logic          credit;
   logic          req;
   logic          resp;
   logic          live;
   logic          push;
   logic          pop;
   logic          valid;

   assign credit = ({1'b0, buf_count} + {1'b0, outstanding}) < DEPTH;
   assign req    = !rst_i && !redirect_i && credit;
   assign resp   = imem_rvalid_i && (outstanding != '0);
   assign live   = resp && (discard_cnt == '0);
   assign valid  = buf_count != '0;
   assign push   = live && !redirect_i;
   assign pop    = valid && instr_ready_i && !redirect_i;

   assign imem_req_o    = req;
   assign imem_addr_o   = fetch_pc;
   assign instr_valid_o = valid;
   assign instr_o       = valid ? buf_ins[buf_rd] : '0;
   assign pc_o          = valid ? buf_pc[buf_rd] : '0;
   assign next_pc_o     = pc_o + PC_STEP;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
         buf_count   <= '0;
         buf_rd      <= '0;
         buf_wr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
      end else begin
         outstanding <= outstanding + CW'(req) - CW'(resp);
         if (redirect_i) begin
            // every in-flight request not answered this cycle is stale
            fetch_pc    <= redirect_pc_i;
            discard_cnt <= outstanding - CW'(resp);
            buf_count   <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
         end else begin
            if (req) begin
               fetch_pc <= fetch_pc + PC_STEP;
               tag_wr   <= tag_wr + 1'b1;
            end
            if (live) begin
               tag_rd <= tag_rd + 1'b1;
            end
            if (resp && !live) begin
               discard_cnt <= discard_cnt - 1'b1;
            end
            if (push) begin
               buf_wr <= buf_wr + 1'b1;
            end
            if (pop) begin
               buf_rd <= buf_rd + 1'b1;
            end
            buf_count <= buf_count + CW'(push) - CW'(pop);
         end
      end
   end

   // storage arrays need no reset; the head is gated by the valid flag
   always_ff @(posedge clk_i) begin
      if (req) begin
         tag_pc[tag_wr] <= fetch_pc;
      end
      if (push && !rst_i) begin
         buf_pc[buf_wr]  <= tag_pc[tag_rd];
         buf_ins[buf_wr] <= imem_rdata_i;
      end
   end

endmodule
